// File: rtl/opr2_unit.sv
// rtl/opr2_unit.sv - group-2 operate microinstruction unit (skip tests, CLA, OSR, HLT)
// Defining OPR2_USER_TRAP_EN makes OSR/HLT in user mode trap instead of executing.

module opr2_unit #(
  parameter int WIDTH = 12
) (
  input  logic             clk100,
  input  logic             reset,
  input  logic             start,
  input  logic [0:11]      instruction,
  input  logic [0:WIDTH-1] ac,
  input  logic             l,
  input  logic [0:WIDTH-1] sr,
  input  logic             user_mode,
  output logic             busy,
  output logic             done,
  output logic             skip,
  output logic [0:WIDTH-1] ac_out,
  output logic             halt,
  output logic             user_trap
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LATCH  = 3'd1;
  localparam logic [2:0] TEST   = 3'd2;
  localparam logic [2:0] UPDATE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [0:11]      instr_q, instr_d;
  logic [0:WIDTH-1] ac_q, ac_d;
  logic [0:WIDTH-1] sr_q, sr_d;
  logic [0:WIDTH-1] ac_out_q, ac_out_d;
  logic             l_q, l_d;
  logic             um_q, um_d;
  logic             ac_zero_q, ac_zero_d;
  logic             ac_neg_q, ac_neg_d;
  logic             skip_q, skip_d;
  logic             done_q, done_d;
  logic             halt_q, halt_d;
  logic             trap_q, trap_d;

  logic             group2;
  logic             trap_hit;
  logic             any_hit;
  logic             cond;
  logic [0:WIDTH-1] result;

  assign group2 = (instr_q[0:3] == 4'b1111) && !instr_q[11];

`ifdef OPR2_USER_TRAP_EN
  assign trap_hit = group2 && um_q && (instr_q[9] || instr_q[10]);
`else
  // user_mode is latched but deliberately has no effect in this build
  assign trap_hit = um_q & 1'b0;
`endif

  always_comb begin
    any_hit = (instr_q[5] & ac_neg_q) | (instr_q[6] & ac_zero_q) | (instr_q[7] & l_q);
    // bit 8 inverts the sense: skip only when none of the selected conditions hold
    cond    = instr_q[8] ? !any_hit : any_hit;
    result  = instr_q[4] ? '0 : ac_q;
    if (instr_q[9] && !trap_hit) begin
      result = result | sr_q;
    end
    if (!group2) begin
      result = ac_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    ac_d      = ac_q;
    sr_d      = sr_q;
    l_d       = l_q;
    um_d      = um_q;
    ac_zero_d = ac_zero_q;
    ac_neg_d  = ac_neg_q;
    skip_d    = skip_q;
    ac_out_d  = ac_out_q;
    done_d    = 1'b0;
    halt_d    = 1'b0;
    trap_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          instr_d = instruction;
          ac_d    = ac;
          sr_d    = sr;
          l_d     = l;
          um_d    = user_mode;
          state_d = LATCH;
        end
      end
      LATCH: begin
        ac_zero_d = (ac_q == '0);
        ac_neg_d  = ac_q[0];
        state_d   = TEST;
      end
      TEST: begin
        skip_d  = group2 && cond;
        state_d = UPDATE;
      end
      UPDATE: begin
        ac_out_d = result;
        state_d  = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        halt_d  = group2 && instr_q[10] && !trap_hit;
        trap_d  = trap_hit;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      ac_q      <= '0;
      sr_q      <= '0;
      l_q       <= 1'b0;
      um_q      <= 1'b0;
      ac_zero_q <= 1'b0;
      ac_neg_q  <= 1'b0;
      skip_q    <= 1'b0;
      ac_out_q  <= '0;
      done_q    <= 1'b0;
      halt_q    <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      ac_q      <= ac_d;
      sr_q      <= sr_d;
      l_q       <= l_d;
      um_q      <= um_d;
      ac_zero_q <= ac_zero_d;
      ac_neg_q  <= ac_neg_d;
      skip_q    <= skip_d;
      ac_out_q  <= ac_out_d;
      done_q    <= done_d;
      halt_q    <= halt_d;
      trap_q    <= trap_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign skip      = skip_q;
  assign ac_out    = ac_out_q;
  assign halt      = halt_q;
  assign user_trap = trap_q;

endmodule
